// File: rtl/switch_pkg.sv
// Shared report-word layout for the egress metadata polling interface.
// Mirrors the software driver header; keep field order in sync.
package switch_pkg;

    localparam int unsigned META_W           = 30;
    localparam int unsigned REPORT_W         = 32;
    localparam int unsigned REPORT_VALID_BIT = 31;
    localparam int unsigned REPORT_OVF_BIT   = 30;

    typedef struct packed {
        logic              valid;
        logic              ovf;
        logic [META_W-1:0] meta;
    } report_word_t;

endpackage

// File: rtl/meta_fifo.sv
// Per-port synchronous FIFO with a wrap-bit pointer pair.
// Pop on empty is ignored; a push into a full FIFO succeeds only with a same-cycle pop.
module meta_fifo #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned META_W = 30
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [META_W-1:0] data_i,
    output logic [META_W-1:0] head_o,
    output logic              empty_o,
    output logic              full_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [META_W-1:0] mem_q [DEPTH];
    logic              do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        do_pop   = pop_i & ~empty_o;
        do_push  = push_i & (~full_o | do_pop);
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/egress_meta_reporter.sv
// Queues per-port egress metadata and presents each FIFO head as a 32-bit report word.
// One pop per rising edge of the software read acknowledge.
module egress_meta_reporter
    import switch_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned DEPTH     = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PORTS-1:0]          meta_in_en,
    input  logic [NUM_PORTS*META_W-1:0]   meta_in,
    input  logic [NUM_PORTS-1:0]          interface_out_ack,
    output logic [NUM_PORTS*REPORT_W-1:0] report_out,
    output logic [NUM_PORTS-1:0]          report_pending
);

    logic [NUM_PORTS-1:0] ack_q;
    logic [NUM_PORTS-1:0] ovf_q, ovf_d;
    logic [NUM_PORTS-1:0] pop_c;
    logic [NUM_PORTS-1:0] fifo_empty, fifo_full;
    logic [META_W-1:0]    fifo_head [NUM_PORTS];
    report_word_t         rw;

    assign pop_c          = interface_out_ack & ~ack_q;
    assign report_pending = ~fifo_empty;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        meta_fifo #(
            .DEPTH  (DEPTH),
            .META_W (META_W)
        ) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .push_i  (meta_in_en[p]),
            .pop_i   (pop_c[p]),
            .data_i  (meta_in[p*META_W +: META_W]),
            .head_o  (fifo_head[p]),
            .empty_o (fifo_empty[p]),
            .full_o  (fifo_full[p])
        );
    end

    // Overflow flag update and report word packing; a drop in the same cycle as a pop wins.
    always_comb begin
        ovf_d      = ovf_q;
        report_out = '0;
        rw         = '0;
        for (int p = 0; p < int'(NUM_PORTS); p++) begin
            if (meta_in_en[p] && fifo_full[p] && !pop_c[p]) begin
                ovf_d[p] = 1'b1;
            end else if (pop_c[p] && !fifo_empty[p]) begin
                ovf_d[p] = 1'b0;
            end
            rw.valid = ~fifo_empty[p];
            rw.ovf   = ovf_q[p];
            rw.meta  = fifo_empty[p] ? '0 : fifo_head[p];
            report_out[p*REPORT_W +: REPORT_W] = rw;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_q <= '0;
            ovf_q <= '0;
        end else begin
            ack_q <= interface_out_ack;
            ovf_q <= ovf_d;
        end
    end

endmodule
